// File: rtl/axi_stream_packet_source_if.sv
//------------------------------------------------------------------------------
// Module   : axi_stream_packet_source_if
// Brief    : Command and AXI4-Stream bundle for the packet source.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axi_stream_packet_source_if #(
  parameter int BYTE_WIDTH = 4,
  parameter int ID_WIDTH   = 1,
  parameter int LEN_WIDTH  = 16
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [LEN_WIDTH-1:0]    cmd_len;
  logic [ID_WIDTH-1:0]     cmd_id;
  logic [7:0]              cmd_seed;

  logic                    tvalid;
  logic                    tready;
  logic [8*BYTE_WIDTH-1:0] tdata;
  logic [BYTE_WIDTH-1:0]   tstrb;
  logic [BYTE_WIDTH-1:0]   tkeep;
  logic                    tlast;
  logic [ID_WIDTH-1:0]     tid;

  // The packet source itself.
  modport master (
    input  cmd_valid, cmd_len, cmd_id, cmd_seed, tready,
    output cmd_ready, tvalid, tdata, tstrb, tkeep, tlast, tid
  );

  // Command producer and stream consumer.
  modport slave (
    output cmd_valid, cmd_len, cmd_id, cmd_seed, tready,
    input  cmd_ready, tvalid, tdata, tstrb, tkeep, tlast, tid
  );
endinterface

`default_nettype wire

// File: rtl/axi_stream_packet_source.sv
//------------------------------------------------------------------------------
// Module   : axi_stream_packet_source
// Brief    : AXI4-Stream master emitting one seeded byte-ramp packet per command.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_stream_packet_source #(
  parameter int BYTE_WIDTH  = 4,
  parameter int ID_WIDTH    = 1,
  parameter int LEN_WIDTH   = 16,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  axi_stream_packet_source_if.master    bus,
  output logic                          busy,
  output logic [COUNT_WIDTH-1:0]        pkt_count
);

  localparam int LOG2_BW = $clog2(BYTE_WIDTH);
  localparam int BEAT_W  = LEN_WIDTH - LOG2_BW + 1;
  localparam int IDX_W   = BEAT_W + LOG2_BW;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  r_state;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [7:0]              r_seed;
  logic [BEAT_W-1:0]       r_beat;
  logic                    r_tvalid;
  logic [8*BYTE_WIDTH-1:0] r_tdata;
  logic [BYTE_WIDTH-1:0]   r_tkeep;
  logic                    r_tlast;
  logic [ID_WIDTH-1:0]     r_tid;
  logic [COUNT_WIDTH-1:0]  r_pkt_count;

  logic [LEN_WIDTH-1:0]    w_src_len;
  logic [7:0]              w_src_seed;
  logic [BEAT_W-1:0]       w_src_beat;
  logic [BEAT_W-1:0]       w_last_beat;
  logic                    w_src_last;
  logic [8*BYTE_WIDTH-1:0] w_data;
  logic [BYTE_WIDTH-1:0]   w_keep;

  // The beat builder prepares beat 0 of the offered command while idle and the
  // beat after the one on the bus while sending, so every output is registered.
  always_comb begin
    w_src_len  = r_len;
    w_src_seed = r_seed;
    w_src_beat = r_beat + BEAT_W'(1);
    if (r_state == IDLE) begin
      w_src_len  = bus.cmd_len;
      w_src_seed = bus.cmd_seed;
      w_src_beat = '0;
    end
  end

  assign w_last_beat = BEAT_W'((w_src_len - LEN_WIDTH'(1)) >> LOG2_BW);
  assign w_src_last  = (w_src_beat == w_last_beat);

  for (genvar k = 0; k < BYTE_WIDTH; k++) begin : g_lane
    logic [IDX_W-1:0] w_idx;
    assign w_idx = (IDX_W'(w_src_beat) << LOG2_BW) | IDX_W'(k);
    assign w_keep[k] = (w_idx < IDX_W'(w_src_len));
    assign w_data[8*k +: 8] = w_keep[k] ? (w_src_seed + 8'(w_idx)) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_seed      <= '0;
      r_beat      <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tkeep     <= '0;
      r_tlast     <= 1'b0;
      r_tid       <= '0;
      r_pkt_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // Zero-length commands are consumed here without leaving IDLE.
          if (bus.cmd_valid && (bus.cmd_len != '0)) begin
            r_state  <= SEND;
            r_len    <= bus.cmd_len;
            r_seed   <= bus.cmd_seed;
            r_beat   <= '0;
            r_tvalid <= 1'b1;
            r_tdata  <= w_data;
            r_tkeep  <= w_keep;
            r_tlast  <= w_src_last;
            r_tid    <= bus.cmd_id;
          end
        end
        SEND: begin
          if (bus.tready) begin
            if (r_tlast) begin
              r_state     <= IDLE;
              r_tvalid    <= 1'b0;
              r_tlast     <= 1'b0;
              r_pkt_count <= r_pkt_count + COUNT_WIDTH'(1);
            end else begin
              r_beat  <= r_beat + BEAT_W'(1);
              r_tdata <= w_data;
              r_tkeep <= w_keep;
              r_tlast <= w_src_last;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == IDLE) && resetn;
  assign bus.tvalid    = r_tvalid;
  assign bus.tdata     = r_tdata;
  assign bus.tkeep     = r_tkeep;
  assign bus.tstrb     = r_tkeep;
  assign bus.tlast     = r_tlast;
  assign bus.tid       = r_tid;
  assign busy          = (r_state == SEND);
  assign pkt_count     = r_pkt_count;

endmodule

`default_nettype wire

// File: tb/tb_axi_stream_packet_source.sv
//------------------------------------------------------------------------------
// Module   : tb_axi_stream_packet_source
// Brief    : Self-checking bench: vector table, corner sequences, random traffic.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_stream_packet_source;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        busy;
  logic [15:0] pkt_count;

  axi_stream_packet_source_if #(.BYTE_WIDTH(4), .ID_WIDTH(1), .LEN_WIDTH(16)) bus ();

  axi_stream_packet_source #(
    .BYTE_WIDTH(4), .ID_WIDTH(1), .LEN_WIDTH(16), .COUNT_WIDTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        id;
  } beat_t;

  typedef struct {
    int          len;
    logic [7:0]  seed;
    logic        id;
    int          nbeats;
    logic [31:0] first_data;
    logic [31:0] last_data;
    logic [3:0]  last_keep;
  } vec_t;

  int    tests = 0;
  int    fails = 0;
  int    exp_pkts = 0;
  bit    rand_mode = 1'b0;
  beat_t exp_q[$];
  beat_t got_q[$];
  vec_t  vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference packet: byte i of the packet is (seed+i) mod 256 for i < len.
  task automatic push_model(input int len, input logic [7:0] seed, input logic id);
    int nb;
    nb = (len + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      beat_t x;
      x = '0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = b * 4 + k;
        if (i < len) begin
          x.data[8*k +: 8] = 8'((int'(seed) + i) % 256);
          x.keep[k] = 1'b1;
        end
      end
      x.last = (b == nb - 1);
      x.id   = id;
      exp_q.push_back(x);
    end
  endtask

  function automatic beat_t cur_beat();
    beat_t x;
    x.data = bus.tdata;
    x.keep = bus.tkeep;
    x.last = bus.tlast;
    x.id   = bus.tid;
    return x;
  endfunction

  // Stream monitor: protocol hold rules plus scoreboard against the model.
  bit    have_prev = 1'b0;
  bit    prev_valid, prev_ready;
  beat_t prev_beat;
  always @(negedge clk) begin
    beat_t c;
    c = cur_beat();
    if (!resetn) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev && prev_valid && !prev_ready) begin
        check("hold_tvalid", bus.tvalid, 1'b1);
        check("hold_beat", c, prev_beat);
      end
      check("tstrb_eq_tkeep", bus.tstrb, bus.tkeep);
      if (bus.tvalid && bus.tready) begin
        got_q.push_back(c);
        if (exp_q.size() == 0) begin
          check("unexpected_beat", c, '0);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat", c, e);
          if (e.last) exp_pkts++;
        end
      end
      have_prev  = 1'b1;
      prev_valid = bus.tvalid;
      prev_ready = bus.tready;
      prev_beat  = c;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) bus.tready = ($urandom % 4) != 0;
    end
  end

  task automatic send_cmd(input int len, input logic [7:0] seed, input logic id);
    int n;
    bus.cmd_len   = 16'(len);
    bus.cmd_seed  = seed;
    bus.cmd_id    = id;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", bus.cmd_ready, 1'b1);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    if (len != 0) begin
      push_model(len, seed, id);
      check("first_tvalid_latency", bus.tvalid, 1'b1);
    end else begin
      check("zero_len_no_tvalid", bus.tvalid, 1'b0);
      check("zero_len_idle", busy, 1'b0);
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{10, 8'h10, 1'b1, 3, 32'h13121110, 32'h00001918, 4'b0011};
    vecs[1] = '{ 8, 8'h20, 1'b0, 2, 32'h23222120, 32'h27262524, 4'b1111};
    vecs[2] = '{ 4, 8'hFE, 1'b1, 1, 32'h0100FFFE, 32'h0100FFFE, 4'b1111};
    vecs[3] = '{ 1, 8'h55, 1'b0, 1, 32'h00000055, 32'h00000055, 4'b0001};
    vecs[4] = '{ 7, 8'hF0, 1'b1, 2, 32'hF3F2F1F0, 32'h00F6F5F4, 4'b0111};

    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.cmd_id    = '0;
    bus.cmd_seed  = '0;
    bus.tready    = 1'b0;
    resetn        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    check("rst_tvalid", bus.tvalid, 1'b0);
    check("rst_tlast", bus.tlast, 1'b0);
    check("rst_tdata", bus.tdata, 32'h0);
    check("rst_tkeep", bus.tkeep, 4'h0);
    check("rst_tid", bus.tid, 1'b0);
    check("rst_pkt_count", pkt_count, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);

    // Vector table with tready held high.
    bus.tready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      got_q.delete();
      send_cmd(vecs[v].len, vecs[v].seed, vecs[v].id);
      drain(50);
      check("vec_nbeats", got_q.size(), vecs[v].nbeats);
      if (got_q.size() > 0) begin
        check("vec_first_data", got_q[0].data, vecs[v].first_data);
        check("vec_last_data", got_q[got_q.size()-1].data, vecs[v].last_data);
        check("vec_last_keep", got_q[got_q.size()-1].keep, vecs[v].last_keep);
        check("vec_last_flag", got_q[got_q.size()-1].last, 1'b1);
        check("vec_tid", got_q[0].id, vecs[v].id);
      end
      check("vec_tvalid_gap", bus.tvalid, 1'b0);
      check("vec_pkt_count", pkt_count, 16'(exp_pkts));
    end

    // Backpressure on beat 1 of a 10-byte packet.
    bus.tready = 1'b0;
    send_cmd(10, 8'h10, 1'b1);
    check("bp_beat0", bus.tdata, 32'h13121110);
    bus.tready = 1'b1;
    @(posedge clk);
    #1;
    bus.tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_data", bus.tdata, 32'h17161514);
      check("bp_hold_keep", bus.tkeep, 4'b1111);
      check("bp_hold_last", bus.tlast, 1'b0);
    end
    check("bp_cmd_ready_low", bus.cmd_ready, 1'b0);
    check("bp_busy", busy, 1'b1);
    bus.tready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_beat2_data", bus.tdata, 32'h00001918);
    check("bp_beat2_keep", bus.tkeep, 4'b0011);
    check("bp_beat2_last", bus.tlast, 1'b1);
    @(posedge clk);
    #1;
    check("bp_end_tvalid", bus.tvalid, 1'b0);
    check("bp_end_tlast", bus.tlast, 1'b0);
    check("bp_pkt_count", pkt_count, 16'(exp_pkts));

    // Zero-length command is consumed silently.
    send_cmd(0, 8'h77, 1'b0);
    check("zero_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    check("zero_tvalid_after", bus.tvalid, 1'b0);
    check("zero_pkt_count", pkt_count, 16'(exp_pkts));

    // Reset in the middle of a packet.
    bus.tready = 1'b0;
    send_cmd(10, 8'h33, 1'b1);
    bus.tready = 1'b1;
    @(posedge clk);
    #1;
    bus.tready = 1'b0;
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("mid_rst_tvalid", bus.tvalid, 1'b0);
    check("mid_rst_tlast", bus.tlast, 1'b0);
    check("mid_rst_pkt_count", pkt_count, 16'h0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_cmd_ready_low", bus.cmd_ready, 1'b0);
    resetn = 1'b1;
    exp_pkts = 0;
    #1;
    check("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    bus.tready = 1'b1;
    send_cmd(4, 8'hA0, 1'b0);
    drain(20);
    check("post_rst_pkt_count", pkt_count, 16'h1);

    // Randomized commands under random backpressure.
    rand_mode = 1'b1;
    for (int r = 0; r < 60; r++) begin
      int len;
      len = ($urandom % 8 == 0) ? int'($urandom_range(100, 200)) : int'($urandom_range(0, 40));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_cmd(len, 8'($urandom), 1'($urandom));
    end
    drain(2000);
    @(posedge clk);
    #1;
    rand_mode = 1'b0;
    check("rand_pkt_count", pkt_count, 16'(exp_pkts));
    check("rand_idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
